sc_result_collector: RTL and testbench
======================================

// Module: sc_result_collector
// PURPOSE
//   Stochastic-to-binary decoder at the output end of the SC convolution row pipeline.
//   Takes the completed top-row bitstreams (x value stream, y scale stream) one bit per beat.
//   Counts the ones per output column over SC_LEN beats.
//   Pushes each finished column {col, count_x, count_y} into an output FIFO with a valid/ready interface.
// PARAMETERS
//   KERNEL_WIDTH  `KERNEL_WIDTH  kernel width; output column = width_index - (KERNEL_WIDTH-1)
//   INPUT_WIDTH   `INPUT_WIDTH   input row width; OUT_COLS = INPUT_WIDTH-KERNEL_WIDTH+1 (localparam)
//   SC_LEN        `SC_LEN        bitstream length (>=2)
//   FIFO_DEPTH    4              result FIFO entries (power of 2)
// PORTS
//   clock        in   1                  single clock domain
//   reset        in   1                  asynchronous, active-low reset
//   in_valid     in   1                  beat present
//   in_ready     out  1                  beat accepted when in_valid && in_ready
//   width_index  in   INPUT_WIDTH_LOG    input column index of beat
//   sc_count     in   SC_LEN_LOG         bit position within stream
//   bit_x        in   1                  value-stream bit
//   bit_y        in   1                  scale-stream bit
//   out_valid    out  1                  FIFO head valid
//   out_ready    in   1                  consumer takes head
//   out_col      out  INPUT_WIDTH_LOG    output column of head
//   out_count_x  out  SC_LEN_LOG+1       ones in x stream, 0..SC_LEN
//   out_count_y  out  SC_LEN_LOG+1       ones in y stream, 0..SC_LEN
//   protocol_err out  1                  sticky: beat with width_index > INPUT_WIDTH-1 accepted
// BEHAVIOUR
//   Reset (reset==0, async):
//   - Accumulators, FIFO pointers and occupancy are cleared.
//   - out_valid=0, protocol_err=0, in_ready=0 while reset is held.
//   - out_col and out_count_* are 0.
//   - Clearing is immediate, with no clock edge needed. An in-flight stream is discarded.
//   in_ready = (fifo occupancy < FIFO_DEPTH). It is driven combinationally from registered occupancy only.
//   Accepted beat, decoded in this order:
//   - width_index > INPUT_WIDTH-1: beat dropped, protocol_err set (sticky until reset).
//   - width_index < KERNEL_WIDTH-1: beat dropped silently (halo column), no error.
//   - Otherwise c = width_index-(KERNEL_WIDTH-1).
//     - sc_count==0: acc_x[c]=bit_x, acc_y[c]=bit_y. A restart overwrites any partial count.
//     - Otherwise: acc_x[c]+=bit_x, acc_y[c]+=bit_y (SC_LEN_LOG+1 bits, never wraps).
//     - sc_count==SC_LEN-1: push {c, acc_x[c]+bit_x, acc_y[c]+bit_y} to FIFO, then clear acc[c].
//   Columns are independent. Beats for different columns may interleave in any order.
//   Latency: the completing beat accepted at edge N gives out_valid=1 after edge N, provided the FIFO was empty.
//   Output FIFO:
//   - out_valid = occupancy != 0.
//   - out_* show the head and hold stable while out_valid && !out_ready.
//   - Pop on out_valid && out_ready. FIFO order = completion order.
//   Simultaneous push and pop in the same cycle: occupancy unchanged, pointers both advance.
//   - When full, no push is possible (in_ready=0). A pop that cycle raises in_ready on the next cycle only.
//   Non-completing beats also stall while the FIFO is full. The stall is intentionally conservative.
// TESTING (KERNEL_WIDTH=3, INPUT_WIDTH=8, SC_LEN=16, FIFO_DEPTH=4)
//   1. Assert reset mid-stream with no clock edge:
//      -> out_valid=0, in_ready=0 immediately.
//      -> After release, in_ready=1. A fresh 16-beat column then decodes correctly.
//   2. width_index=2, sc_count 0..15, bit_x=1 on 10 beats, bit_y=1 on all beats:
//      -> exactly one result {col=0, x=10, y=16}, out_valid high one edge after the last beat.
//   3. width_index=1 for 16 beats, then width_index=9 for 1 beat:
//      -> no output; protocol_err=1 and stays 1.
//   4. width_index=3: sc_count 0..7 with bit_x=1, then sc_count 0..15 with bit_x=0:
//      -> {col=1, x=0}. The restart discards the partial count.
//   5. out_ready=0, complete columns 0..4 interleaved bit by bit:
//      -> in_ready drops after the 4th push; column 4 is held.
//      -> Raise out_ready: results pop in completion order, and column 4 completes after the first pop.
//   6. FIFO at 3 entries, push and pop in the same cycle:
//      -> occupancy stays 3; no data lost or duplicated.

Source files
------------

// File: rtl/sc_result_collector.sv
// Stochastic-to-binary decoder: counts ones per output column over SC_LEN beats
// and queues finished {col, count_x, count_y} results in a small valid/ready FIFO.
module sc_result_collector #(
  parameter int KERNEL_WIDTH = 3,
  parameter int INPUT_WIDTH  = 8,
  parameter int SC_LEN       = 16,
  parameter int FIFO_DEPTH   = 4,
  localparam int INPUT_WIDTH_LOG = $clog2(INPUT_WIDTH) + 1,
  localparam int SC_LEN_LOG      = $clog2(SC_LEN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INPUT_WIDTH_LOG-1:0] width_index,
  input  logic [SC_LEN_LOG-1:0]      sc_count,
  input  logic                       bit_x,
  input  logic                       bit_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_WIDTH_LOG-1:0] out_col,
  output logic [SC_LEN_LOG:0]        out_count_x,
  output logic [SC_LEN_LOG:0]        out_count_y,
  output logic                       protocol_err
);

  localparam int OUT_COLS = INPUT_WIDTH - KERNEL_WIDTH + 1;
  localparam int CNT_W    = SC_LEN_LOG + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [INPUT_WIDTH_LOG-1:0] LAST_IDX  = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);
  localparam logic [INPUT_WIDTH_LOG-1:0] HALO      = INPUT_WIDTH_LOG'(KERNEL_WIDTH - 1);
  localparam logic [SC_LEN_LOG-1:0]      LAST_BEAT = SC_LEN_LOG'(SC_LEN - 1);
  localparam logic [PTR_W:0]             DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  logic [CNT_W-1:0]           acc_x_p1 [OUT_COLS];
  logic [CNT_W-1:0]           acc_y_p1 [OUT_COLS];
  logic [INPUT_WIDTH_LOG-1:0] fifo_col [FIFO_DEPTH];
  logic [CNT_W-1:0]           fifo_x   [FIFO_DEPTH];
  logic [CNT_W-1:0]           fifo_y   [FIFO_DEPTH];
  logic [PTR_W:0]             occ;
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;

  logic                       vld_p0, bad_p0, halo_p0, hit_p0, first_p0, push_p0, pop;
  logic [INPUT_WIDTH_LOG-1:0] col_p0;
  logic [CNT_W-1:0]           sel_x_p0, sel_y_p0, sum_x_p0, sum_y_p0;

  // Stage 0: beat decode and running-sum for the addressed column.
  // Ready is gated by reset so the upstream sees no acceptance while held.
  assign in_ready = reset & (occ < DEPTH_C);
  assign vld_p0   = in_valid & in_ready;
  assign bad_p0   = width_index > LAST_IDX;
  assign halo_p0  = width_index < HALO;
  assign hit_p0   = vld_p0 & ~bad_p0 & ~halo_p0;
  assign col_p0   = width_index - HALO;
  assign first_p0 = (sc_count == '0);
  assign push_p0  = hit_p0 & (sc_count == LAST_BEAT);
  assign pop      = out_valid & out_ready;

  always_comb begin
    sel_x_p0 = '0;
    sel_y_p0 = '0;
    for (int i = 0; i < OUT_COLS; i++) begin
      if (col_p0 == INPUT_WIDTH_LOG'(i)) begin
        sel_x_p0 = acc_x_p1[i];
        sel_y_p0 = acc_y_p1[i];
      end
    end
  end

  // A beat at position 0 restarts the column, discarding any partial count.
  assign sum_x_p0 = (first_p0 ? '0 : sel_x_p0) + CNT_W'(bit_x);
  assign sum_y_p0 = (first_p0 ? '0 : sel_y_p0) + CNT_W'(bit_y);

  // Stage 1: per-column accumulators, cleared on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_x_p1 <= '{default: '0};
      acc_y_p1 <= '{default: '0};
    end else if (hit_p0) begin
      for (int i = 0; i < OUT_COLS; i++) begin
        if (col_p0 == INPUT_WIDTH_LOG'(i)) begin
          acc_x_p1[i] <= push_p0 ? '0 : sum_x_p0;
          acc_y_p1[i] <= push_p0 ? '0 : sum_y_p0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_p0) begin
      fifo_col[wr_ptr] <= col_p0;
      fifo_x[wr_ptr]   <= sum_x_p0;
      fifo_y[wr_ptr]   <= sum_y_p0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (vld_p0 & bad_p0) protocol_err <= 1'b1;
    end
  end

  // Head is masked to zero when empty so outputs read 0 in and after reset.
  assign out_valid   = (occ != '0);
  assign out_col     = out_valid ? fifo_col[rd_ptr] : '0;
  assign out_count_x = out_valid ? fifo_x[rd_ptr]   : '0;
  assign out_count_y = out_valid ? fifo_y[rd_ptr]   : '0;

endmodule

// File: tb/tb_sc_result_collector.sv
// Directed bench for sc_result_collector (KERNEL_WIDTH=3, INPUT_WIDTH=8, SC_LEN=16, FIFO_DEPTH=4).
module tb_sc_result_collector;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       bit_x = 1'b0;
  logic       bit_y = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] width_index = '0;
  logic [3:0] sc_count = '0;
  logic       in_ready, out_valid, protocol_err;
  logic [3:0] out_col;
  logic [4:0] out_count_x, out_count_y;

  int checks = 0;
  int errors = 0;

  sc_result_collector #(
    .KERNEL_WIDTH(3), .INPUT_WIDTH(8), .SC_LEN(16), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .width_index(width_index), .sc_count(sc_count),
    .bit_x(bit_x), .bit_y(bit_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_count_x(out_count_x), .out_count_y(out_count_y),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  task automatic send_beat(input logic [3:0] wi, input logic [3:0] sc, input logic bx, input logic by);
    int n;
    width_index = wi; sc_count = sc; bit_x = bx; bit_y = by; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_accept wi=%0d sc=%0d: in_ready=%0b, required 1", wi, sc, in_ready);
    end else begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_head(output logic v, output logic [3:0] c, output logic [4:0] x, output logic [4:0] y);
    v = out_valid; c = out_col; x = out_count_x; y = out_count_y;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_power_on();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL por_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL por_in_ready: got %0b want 0", in_ready); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL por_protocol_err: got %0b want 0", protocol_err); end
    checks++; if ({out_col, out_count_x, out_count_y} !== 14'd0) begin errors++;
      $display("FAIL por_head: got col=%0d x=%0d y=%0d want 0/0/0", out_col, out_count_x, out_count_y); end
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL por_release_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single_column();
    for (int s = 0; s < 16; s++) begin
      if (s == 15) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", out_valid); end
      end
      send_beat(4'd2, 4'(s), (s < 10), 1'b1);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: out_valid=%0b want 1", out_valid); end
    checks++; if ({out_col, out_count_x, out_count_y} !== {4'd0, 5'd10, 5'd16}) begin errors++;
      $display("FAIL single_result: got col=%0d x=%0d y=%0d want 0/10/16", out_col, out_count_x, out_count_y); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_result: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_halo_protocol();
    for (int s = 0; s < 16; s++) send_beat(4'd1, 4'(s), 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halo_output: out_valid=%0b want 0", out_valid); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL halo_no_err: protocol_err=%0b want 0", protocol_err); end
    send_beat(4'd9, 4'd0, 1'b1, 1'b1);
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %0b want 1", protocol_err); end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky: got %0b want 1", protocol_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL proto_output: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_reset();
    logic v; logic [3:0] c; logic [4:0] x, y;
    for (int s = 0; s < 16; s++) send_beat(4'd3, 4'(s), (s < 5), 1'b1);
    for (int s = 0; s < 5; s++) begin
      send_beat(4'd2, 4'(s), 1'b1, 1'b1);
      send_beat(4'd4, 4'(s), 1'b1, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %0b want 0", in_ready); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_async_err: got %0b want 0", protocol_err); end
    checks++; if ({out_col, out_count_x} !== 9'd0) begin errors++;
      $display("FAIL rst_async_head: got col=%0d x=%0d want 0/0", out_col, out_count_x); end
    @(posedge clock);
    #3 reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid: got %0b want 0", out_valid); end
    for (int s = 5; s < 16; s++) send_beat(4'd4, 4'(s), 1'b1, 1'b1);
    for (int s = 0; s < 16; s++) send_beat(4'd2, 4'(s), s[0], (s < 3));
    take_head(v, c, x, y);
    checks++; if ({v, c, x, y} !== {1'b1, 4'd2, 5'd11, 5'd11}) begin errors++;
      $display("FAIL rst_acc_cleared: got v=%0b col=%0d x=%0d y=%0d want 1/2/11/11", v, c, x, y); end
    take_head(v, c, x, y);
    checks++; if ({v, c, x, y} !== {1'b1, 4'd0, 5'd8, 5'd3}) begin errors++;
      $display("FAIL rst_fresh_column: got v=%0b col=%0d x=%0d y=%0d want 1/0/8/3", v, c, x, y); end
  endtask

  task automatic test_restart();
    for (int s = 0; s < 8; s++) send_beat(4'd3, 4'(s), 1'b1, 1'b1);
    for (int s = 0; s < 16; s++) send_beat(4'd3, 4'(s), 1'b0, 1'b1);
    checks++; if ({out_valid, out_col, out_count_x, out_count_y} !== {1'b1, 4'd1, 5'd0, 5'd16}) begin errors++;
      $display("FAIL restart_result: got v=%0b col=%0d x=%0d y=%0d want 1/1/0/16", out_valid, out_col, out_count_x, out_count_y); end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL restart_single: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gc [5];
    logic [4:0] gx [5];
    logic [4:0] gy [5];
    int got, k_acc;
    logic acc;
    out_ready = 1'b0;
    for (int s = 0; s < 15; s++)
      for (int c = 0; c < 5; c++) send_beat(4'(c + 2), 4'(s), (s < 3 + c), (s < 10 - c));
    for (int c = 0; c < 4; c++) send_beat(4'(c + 2), 4'd15, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %0b want 0", in_ready); end
    width_index = 4'd6; sc_count = 4'd15; bit_x = 1'b0; bit_y = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_col4_held: in_ready=%0b want 0", in_ready); end
    checks++; if (out_col !== 4'd0) begin errors++; $display("FAIL bp_head_stable: out_col=%0d want 0", out_col); end
    got = 0; k_acc = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (out_valid && got < 5) begin
        gc[got] = out_col; gx[got] = out_count_x; gy[got] = out_count_y; got++;
      end
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      if (acc) begin in_valid = 1'b0; k_acc = k; end
    end
    out_ready = 1'b0;
    checks++; if (k_acc !== 1) begin errors++; $display("FAIL bp_col4_after_pop: accepted at cycle %0d want 1", k_acc); end
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d results want 5", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if ({gc[i], gx[i], gy[i]} !== {4'(i), 5'(3 + i), 5'(10 - i)}) begin errors++;
        $display("FAIL bp_order[%0d]: got col=%0d x=%0d y=%0d want %0d/%0d/%0d", i, gc[i], gx[i], gy[i], i, 3 + i, 10 - i); end
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_push_pop();
    logic v; logic [3:0] c; logic [4:0] x, y;
    int n;
    out_ready = 1'b0;
    for (int s = 0; s < 15; s++)
      for (int cc = 0; cc < 4; cc++) send_beat(4'(cc + 2), 4'(s), (s < cc + 1), 1'b1);
    for (int cc = 0; cc < 3; cc++) send_beat(4'(cc + 2), 4'd15, 1'b0, 1'b1);
    width_index = 4'd5; sc_count = 4'd15; bit_x = 1'b0; bit_y = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready_at3: got %0b want 1", in_ready); end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_occ_kept: in_ready=%0b want 1", in_ready); end
    checks++; if (out_col !== 4'd1) begin errors++; $display("FAIL pp_head_after: out_col=%0d want 1", out_col); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      take_head(v, c, x, y);
      if (v) begin
        checks++;
        if ({c, x, y} !== {4'(n + 1), 5'(n + 2), 5'd16}) begin errors++;
          $display("FAIL pp_entry[%0d]: got col=%0d x=%0d y=%0d want %0d/%0d/16", n, c, x, y, n + 1, n + 2); end
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL pp_entry_count: got %0d want 3", n); end
  endtask

  initial begin
    test_power_on();
    test_single_column();
    test_halo_protocol();
    test_reset();
    test_restart();
    test_back_to_back();
    test_push_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
